// File: rtl/keypad_scanner.sv
// 4x4 active-low key matrix scanner: synchronizes rows, scans columns, debounces
// press and release, and holds the last accepted key code for the calculator core.
module keypad_scanner #(
   parameter int unsigned SCAN_DIV     = 1000,
   parameter int unsigned DEBOUNCE_CNT = 200000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  row_in,
   output logic [3:0]  col_out,
   output logic        key_pressed,
   output logic [24:0] keypad_out
);

   localparam int unsigned DW = $clog2(SCAN_DIV);
   localparam int unsigned BW = $clog2(DEBOUNCE_CNT);
   localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
   localparam logic [BW-1:0] DEB_LAST   = BW'(DEBOUNCE_CNT - 1);

   typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED} state_t;

   state_t        state, state_nxt;
   logic [3:0]    row_meta, row_sync;
   logic [1:0]    col, col_nxt;
   logic [1:0]    cap_row, cap_row_nxt;
   logic [1:0]    low_row_c;
   logic [DW-1:0] dwell, dwell_nxt;
   logic [BW-1:0] deb, deb_nxt;
   logic          key_pressed_nxt;
   logic [24:0]   keypad_out_nxt;

   function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
      case ({r, c})
         4'h0: return 4'h1;
         4'h1: return 4'h2;
         4'h2: return 4'h3;
         4'h3: return 4'hA;
         4'h4: return 4'h4;
         4'h5: return 4'h5;
         4'h6: return 4'h6;
         4'h7: return 4'hB;
         4'h8: return 4'h7;
         4'h9: return 4'h8;
         4'hA: return 4'h9;
         4'hB: return 4'hC;
         4'hC: return 4'hF;
         4'hD: return 4'h0;
         4'hE: return 4'hE;
         default: return 4'hD;
      endcase
   endfunction

   // Lowest-index row reading low wins when several keys share the column
   always_comb begin
      low_row_c = 2'd3;
      if (!row_sync[0])      low_row_c = 2'd0;
      else if (!row_sync[1]) low_row_c = 2'd1;
      else if (!row_sync[2]) low_row_c = 2'd2;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         row_meta    <= 4'hF;
         row_sync    <= 4'hF;
         state       <= SCAN;
         col         <= 2'd0;
         cap_row     <= 2'd0;
         dwell       <= '0;
         deb         <= '0;
         key_pressed <= 1'b0;
         keypad_out  <= '0;
         col_out     <= 4'b1110;
      end else begin
         row_meta    <= row_in;
         row_sync    <= row_meta;
         state       <= state_nxt;
         col         <= col_nxt;
         cap_row     <= cap_row_nxt;
         dwell       <= dwell_nxt;
         deb         <= deb_nxt;
         key_pressed <= key_pressed_nxt;
         keypad_out  <= keypad_out_nxt;
         col_out     <= 4'(~(4'b0001 << col_nxt));
      end
   end

   always_comb begin
      state_nxt       = state;
      col_nxt         = col;
      cap_row_nxt     = cap_row;
      dwell_nxt       = dwell;
      deb_nxt         = deb;
      key_pressed_nxt = key_pressed;
      keypad_out_nxt  = keypad_out;
      case (state)
         SCAN: begin
            if (dwell == DWELL_LAST) begin
               dwell_nxt = '0;
               if (row_sync != 4'hF) begin
                  cap_row_nxt = low_row_c;
                  deb_nxt     = '0;
                  state_nxt   = DEBOUNCE;
               end else begin
                  col_nxt = col + 2'd1;
               end
            end else begin
               dwell_nxt = dwell + DW'(1);
            end
         end
         DEBOUNCE: begin
            if (row_sync[cap_row]) begin
               // bounce during press: resume scanning at the next column
               state_nxt = SCAN;
               col_nxt   = col + 2'd1;
               dwell_nxt = '0;
            end else if (deb == DEB_LAST) begin
               keypad_out_nxt  = 25'(key_code(cap_row, col));
               key_pressed_nxt = 1'b1;
               deb_nxt         = '0;
               state_nxt       = PRESSED;
            end else begin
               deb_nxt = deb + BW'(1);
            end
         end
         PRESSED: begin
            if (!row_sync[cap_row]) begin
               deb_nxt = '0;
            end else if (deb == DEB_LAST) begin
               key_pressed_nxt = 1'b0;
               deb_nxt         = '0;
               state_nxt       = SCAN;
               col_nxt         = col + 2'd1;
               dwell_nxt       = '0;
            end else begin
               deb_nxt = deb + BW'(1);
            end
         end
         default: state_nxt = SCAN;
      endcase
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: key-matrix timeline stimulus compared
// against a segment-level reference model of scan, debounce and release.
module tb_keypad_scanner;

   localparam int SD   = 4;
   localparam int DB   = 8;
   localparam int MAXL = 128;
   localparam logic [3:0] KMAP [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                                        4'h7, 4'h8, 4'h9, 4'hC, 4'hF, 4'h0, 4'hE, 4'hD};

   logic        clk, rst;
   logic [3:0]  row_in, col_out;
   logic        key_pressed;
   logic [24:0] keypad_out;
   logic [15:0] keys;

   logic [15:0] plan    [0:MAXL];
   logic        exp_kp  [0:MAXL];
   logic        obs_kp  [0:MAXL];
   logic [24:0] exp_out [0:MAXL];
   logic [24:0] obs_out [0:MAXL];
   logic [3:0]  exp_col [0:MAXL];
   logic [3:0]  obs_col [0:MAXL];

   int n_cmp = 0;
   int n_bad = 0;

   keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DB)) dut (
      .clk(clk), .rst(rst), .row_in(row_in), .col_out(col_out),
      .key_pressed(key_pressed), .keypad_out(keypad_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Physical matrix: key (r,c) is bit r*4+c; a row reads low when a held key sits on the driven column
   always_comb begin
      row_in = 4'hF;
      for (int r = 0; r < 4; r++) row_in[r] = ~|(keys[r*4 +: 4] & ~col_out);
   end

   function automatic logic [3:0] rows_at(input int k, input int c);
      logic [3:0] v = 4'hF;
      if (k < 0) return v;
      for (int r = 0; r < 4; r++) v[r] = ~plan[k][r*4+c];
      return v;
   endfunction

   function automatic void fill(input int a, input int b, input logic kp, input logic [24:0] out,
                                input int c, input int len);
      for (int e = a; e <= b && e <= len; e++) begin
         exp_kp[e]  = kp;
         exp_out[e] = out;
         exp_col[e] = 4'(~(4'b0001 << c));
      end
   endfunction

   // Segment model: each row sample seen at edge e is the matrix of cycle e-3
   function automatic void run_model(input int len);
      int t, c, d, r, bnc, f, run;
      logic [24:0] out;
      logic [3:0]  rs;
      t = 0; c = 0; out = '0;
      while (t <= len) begin
         d = t + SD;
         if (d > len) begin fill(t, len, 1'b0, out, c, len); break; end
         rs = rows_at(d - 3, c);
         if (rs == 4'hF) begin
            fill(t, d - 1, 1'b0, out, c, len);
            t = d; c = (c + 1) % 4;
            continue;
         end
         r = (!rs[0]) ? 0 : (!rs[1]) ? 1 : (!rs[2]) ? 2 : 3;
         bnc = -1;
         for (int e = d + 1; e <= d + DB && e <= len; e++) begin
            rs = rows_at(e - 3, c);
            if (bnc < 0 && rs[r]) bnc = e;
         end
         if (bnc >= 0) begin
            fill(t, bnc - 1, 1'b0, out, c, len);
            t = bnc; c = (c + 1) % 4;
            continue;
         end
         if (d + DB > len) begin fill(t, len, 1'b0, out, c, len); break; end
         fill(t, d + DB - 1, 1'b0, out, c, len);
         out = 25'(KMAP[r*4+c]);
         f = -1; run = 0;
         for (int e = d + DB + 1; e <= len; e++) begin
            rs  = rows_at(e - 3, c);
            run = rs[r] ? run + 1 : 0;
            if (f < 0 && run == DB) f = e;
         end
         if (f < 0) begin fill(d + DB, len, 1'b1, out, c, len); break; end
         fill(d + DB, f - 1, 1'b1, out, c, len);
         t = f; c = (c + 1) % 4;
      end
   endfunction

   function automatic void clear_plan();
      for (int t = 0; t <= MAXL; t++) plan[t] = '0;
   endfunction

   function automatic void hold_key(input int k, input int a, input int b);
      for (int t = a; t <= b; t++) plan[t][k] = 1'b1;
   endfunction

   // Reset, then play plan[] one entry per cycle and record outputs after each edge
   task automatic run_plan(input int len);
      rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      keys = plan[0];
      obs_kp[0] = key_pressed; obs_out[0] = keypad_out; obs_col[0] = col_out;
      for (int e = 1; e <= len; e++) begin
         @(posedge clk);
         #1;
         obs_kp[e] = key_pressed; obs_out[e] = keypad_out; obs_col[e] = col_out;
         keys = plan[e];
      end
      run_model(len);
   endtask

   task automatic test_reset();
      keys = 16'($urandom);
      rst  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if (key_pressed !== 1'b0) begin n_bad++; $display("FAIL reset_kp: got %b want 0", key_pressed); end
      n_cmp++;
      if (keypad_out !== 25'd0) begin n_bad++; $display("FAIL reset_out: got %h want 0", keypad_out); end
      n_cmp++;
      if (col_out !== 4'b1110) begin n_bad++; $display("FAIL reset_col: got %b want 1110", col_out); end
      keys = '0;
   endtask

   task automatic test_idle_scan();
      int bad;
      logic [3:0] want;
      clear_plan();
      run_plan(40);
      for (int i = 0; i < 5; i++) begin
         want = 4'(~(4'b0001 << (i % 4)));
         n_cmp++;
         if (obs_col[4*i] !== want || obs_col[4*i+3] !== want) begin
            n_bad++;
            $display("FAIL idle_col step %0d: got %b/%b want %b", i, obs_col[4*i], obs_col[4*i+3], want);
         end
      end
      bad = -1;
      for (int e = 0; e <= 40; e++)
         if (bad < 0 && (obs_kp[e] !== exp_kp[e] || obs_out[e] !== exp_out[e] || obs_col[e] !== exp_col[e])) bad = e;
      n_cmp++;
      if (bad >= 0) begin
         n_bad++;
         $display("FAIL idle_traj edge %0d: got kp=%b out=%h col=%b want kp=%b out=%h col=%b",
                  bad, obs_kp[bad], obs_out[bad], obs_col[bad], exp_kp[bad], exp_out[bad], exp_col[bad]);
      end
   endtask

   task automatic test_hold_release();
      int bad;
      clear_plan();
      hold_key(6, 0, 29);
      run_plan(45);
      n_cmp++;
      if (obs_kp[19] !== 1'b0 || obs_kp[20] !== 1'b1 || obs_out[20] !== 25'd6) begin
         n_bad++;
         $display("FAIL hold_rise: got kp19=%b kp20=%b out=%h want 0 1 6", obs_kp[19], obs_kp[20], obs_out[20]);
      end
      n_cmp++;
      if (obs_kp[39] !== 1'b1 || obs_kp[40] !== 1'b0 || obs_out[45] !== 25'd6) begin
         n_bad++;
         $display("FAIL hold_fall: got kp39=%b kp40=%b out=%h want 1 0 6", obs_kp[39], obs_kp[40], obs_out[45]);
      end
      bad = -1;
      for (int e = 0; e <= 45; e++)
         if (bad < 0 && (obs_kp[e] !== exp_kp[e] || obs_out[e] !== exp_out[e] || obs_col[e] !== exp_col[e])) bad = e;
      n_cmp++;
      if (bad >= 0) begin
         n_bad++;
         $display("FAIL hold_traj edge %0d: got kp=%b out=%h col=%b want kp=%b out=%h col=%b",
                  bad, obs_kp[bad], obs_out[bad], obs_col[bad], exp_kp[bad], exp_out[bad], exp_col[bad]);
      end
   endtask

   task automatic test_press_bounce();
      int bad;
      clear_plan();
      hold_key(12, 0, 40);
      plan[7][12] = 1'b0;
      run_plan(40);
      n_cmp++;
      if (obs_col[10] !== 4'b1101 || obs_kp[10] !== 1'b0) begin
         n_bad++;
         $display("FAIL bounce_return: got col=%b kp=%b want 1101 0", obs_col[10], obs_kp[10]);
      end
      n_cmp++;
      if (obs_kp[33] !== 1'b0 || obs_kp[34] !== 1'b1 || obs_out[34] !== 25'hF) begin
         n_bad++;
         $display("FAIL bounce_accept: got kp33=%b kp34=%b out=%h want 0 1 f", obs_kp[33], obs_kp[34], obs_out[34]);
      end
      bad = -1;
      for (int e = 0; e <= 40; e++)
         if (bad < 0 && (obs_kp[e] !== exp_kp[e] || obs_out[e] !== exp_out[e] || obs_col[e] !== exp_col[e])) bad = e;
      n_cmp++;
      if (bad >= 0) begin
         n_bad++;
         $display("FAIL bounce_traj edge %0d: got kp=%b out=%h col=%b want kp=%b out=%h col=%b",
                  bad, obs_kp[bad], obs_out[bad], obs_col[bad], exp_kp[bad], exp_out[bad], exp_col[bad]);
      end
   endtask

   task automatic test_release_bounce();
      int bad, rises, falls;
      clear_plan();
      hold_key(3, 0, 29);
      plan[33][3] = 1'b1;
      run_plan(55);
      rises = 0; falls = 0;
      for (int e = 1; e <= 55; e++) begin
         if (obs_kp[e] && !obs_kp[e-1]) rises++;
         if (!obs_kp[e] && obs_kp[e-1]) falls++;
      end
      n_cmp++;
      if (rises != 1 || falls != 1 || obs_kp[43] !== 1'b1 || obs_kp[44] !== 1'b0) begin
         n_bad++;
         $display("FAIL relbounce_edges: got rises=%0d falls=%0d kp43=%b kp44=%b want 1 1 1 0",
                  rises, falls, obs_kp[43], obs_kp[44]);
      end
      n_cmp++;
      if (obs_out[55] !== 25'hA) begin n_bad++; $display("FAIL relbounce_out: got %h want a", obs_out[55]); end
      bad = -1;
      for (int e = 0; e <= 55; e++)
         if (bad < 0 && (obs_kp[e] !== exp_kp[e] || obs_out[e] !== exp_out[e] || obs_col[e] !== exp_col[e])) bad = e;
      n_cmp++;
      if (bad >= 0) begin
         n_bad++;
         $display("FAIL relbounce_traj edge %0d: got kp=%b out=%h col=%b want kp=%b out=%h col=%b",
                  bad, obs_kp[bad], obs_out[bad], obs_col[bad], exp_kp[bad], exp_out[bad], exp_col[bad]);
      end
   endtask

   task automatic test_two_keys();
      clear_plan();
      hold_key(1, 0, 30);
      hold_key(9, 0, 30);
      run_plan(30);
      n_cmp++;
      if (obs_kp[16] !== 1'b1 || obs_out[16] !== 25'd2) begin
         n_bad++;
         $display("FAIL two_keys: got kp=%b out=%h want 1 2", obs_kp[16], obs_out[16]);
      end
   endtask

   task automatic test_second_key_ignored();
      int bad;
      clear_plan();
      hold_key(4, 0, 29);
      hold_key(0, 15, 35);
      hold_key(11, 15, 35);
      run_plan(60);
      n_cmp++;
      if (obs_kp[20] !== 1'b1 || obs_kp[39] !== 1'b1 || obs_kp[40] !== 1'b0 || obs_out[60] !== 25'd4) begin
         n_bad++;
         $display("FAIL second_key: got kp20=%b kp39=%b kp40=%b out=%h want 1 1 0 4",
                  obs_kp[20], obs_kp[39], obs_kp[40], obs_out[60]);
      end
      bad = -1;
      for (int e = 0; e <= 60; e++)
         if (bad < 0 && (obs_kp[e] !== exp_kp[e] || obs_out[e] !== exp_out[e] || obs_col[e] !== exp_col[e])) bad = e;
      n_cmp++;
      if (bad >= 0) begin
         n_bad++;
         $display("FAIL second_traj edge %0d: got kp=%b out=%h col=%b want kp=%b out=%h col=%b",
                  bad, obs_kp[bad], obs_out[bad], obs_col[bad], exp_kp[bad], exp_out[bad], exp_col[bad]);
      end
   endtask

   task automatic test_reset_mid_press();
      int rise_at;
      clear_plan();
      hold_key(6, 0, MAXL);
      run_plan(30);
      n_cmp++;
      if (obs_kp[30] !== 1'b1) begin n_bad++; $display("FAIL midrst_pre: got kp=%b want 1", obs_kp[30]); end
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      n_cmp++;
      if (key_pressed !== 1'b0 || keypad_out !== 25'd0 || col_out !== 4'b1110) begin
         n_bad++;
         $display("FAIL midrst_clear: got kp=%b out=%h col=%b want 0 0 1110", key_pressed, keypad_out, col_out);
      end
      rise_at = -1;
      for (int e = 1; e <= 40; e++) begin
         @(posedge clk);
         #1;
         if (rise_at < 0 && key_pressed === 1'b1) rise_at = e;
      end
      n_cmp++;
      if (rise_at != 20 || keypad_out !== 25'd6) begin
         n_bad++;
         $display("FAIL midrst_reaccept: got rise edge %0d out=%h want 20 6", rise_at, keypad_out);
      end
      keys = '0;
   endtask

   task automatic test_random();
      int bad, k, p, q, k2, a;
      for (int it = 0; it < 10; it++) begin
         clear_plan();
         k = $urandom_range(0, 15);
         p = $urandom_range(0, 15);
         q = p + $urandom_range(10, 50);
         hold_key(k, p, q);
         repeat ($urandom_range(0, 3)) plan[$urandom_range(p, q)][k] = 1'b0;
         if ($urandom_range(0, 1) == 1) begin
            k2 = $urandom_range(0, 15);
            a  = $urandom_range(0, 60);
            hold_key(k2, a, a + $urandom_range(5, 30));
         end
         run_plan(100);
         bad = -1;
         for (int e = 0; e <= 100; e++)
            if (bad < 0 && (obs_kp[e] !== exp_kp[e] || obs_out[e] !== exp_out[e] || obs_col[e] !== exp_col[e])) bad = e;
         n_cmp++;
         if (bad >= 0) begin
            n_bad++;
            $display("FAIL rand%0d_traj edge %0d: got kp=%b out=%h col=%b want kp=%b out=%h col=%b",
                     it, bad, obs_kp[bad], obs_out[bad], obs_col[bad], exp_kp[bad], exp_out[bad], exp_col[bad]);
         end
         bad = -1;
         for (int e = 1; e <= 100; e++)
            if (bad < 0 && obs_out[e] !== obs_out[e-1] && !(obs_kp[e] === 1'b1 && obs_kp[e-1] === 1'b0)) bad = e;
         n_cmp++;
         if (bad >= 0) begin
            n_bad++;
            $display("FAIL rand%0d_out_on_rise edge %0d: got out change %h->%h with kp %b->%b want change only on rise",
                     it, bad, obs_out[bad-1], obs_out[bad], obs_kp[bad-1], obs_kp[bad]);
         end
      end
   endtask

   initial begin
      rst  = 1'b1;
      keys = '0;
      test_reset();
      test_idle_scan();
      test_hold_release();
      test_press_bounce();
      test_release_bounce();
      test_two_keys();
      test_second_key_ignored();
      test_reset_mid_press();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
